multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 3, width of ALU_op_o (legal >= 3; codes zero-extended).
REQ-002 Parameter MEM_TIMEOUT, default 15, max consecutive not-ready memory cycles (legal 1..255).
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 instr_op_i  input  6  opcode field of the instruction register.
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 mem_ready_i  input  1  memory completes the current access this cycle.
REQ-008 pc_write_o, ir_write_o, mem_read_o, mem_write_o, RegWrite_o, ALUSrcA_o  output  1 each  datapath strobes/selects.
REQ-009 RegDst_o, ALUSrcB_o, MemtoReg_o, PCSource_o  output  2 each  datapath mux selects.
REQ-010 ALU_op_o  output  ALU_OP_W  ALU operation code.
REQ-011 illegal_o, timeout_o  output  1 each  sticky error flags.
REQ-012 state_o  output  4  current state encoding, for debug.

Function
REQ-013 States and encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9, JAL 10, TRAP 11.
REQ-014 Opcodes: R-type 000000, addi 001000, slti 001010, ori 001101, lui 001111, beq 000100, bne 000101, lw 100011, sw 101011, j 000010, jal 000011.
REQ-015 ALU_op codes: add 000, sub 001, lui 010, ori 011, R-type/funct 100, bne 101, slti 110.
REQ-016 FETCH: mem_read_o=1, ALUSrcA_o=0, ALUSrcB_o=01, ALU_op add; in the cycle with mem_ready_i=1, ir_write_o=1 and pc_write_o=1 (PCSource 00), next DECODE; otherwise stay.
REQ-017 DECODE: ALUSrcB_o=11, ALU_op add (branch target); opcode latched into an internal register; all strobes 0.
REQ-018 DECODE next: lw/sw -> MEM_ADDR; R-type/addi/slti/ori/lui -> EXEC; beq/bne -> BRANCH; j -> JUMP; jal -> JAL; any other opcode -> TRAP with illegal_o set.
REQ-019 MEM_ADDR: ALUSrcA_o=1, ALUSrcB_o=10, add; next MEM_RD (lw) or MEM_WR (sw).
REQ-020 MEM_RD: mem_read_o=1; on mem_ready_i -> MEM_WB. MEM_WB: RegWrite_o=1, RegDst_o=00, MemtoReg_o=01; next FETCH.
REQ-021 MEM_WR: mem_write_o=1; on mem_ready_i -> FETCH.
REQ-022 EXEC: ALUSrcA_o=1; ALUSrcB_o=00 and funct code for R-type, else 10 with the REQ-015 code; next ALU_WB.
REQ-023 ALU_WB: RegWrite_o=1, MemtoReg_o=00, RegDst_o=01 for R-type else 00; next FETCH.
REQ-024 BRANCH: ALUSrcA_o=1, ALUSrcB_o=00, ALU_op sub (beq) or bne; PCSource_o=01; pc_write_o=zero_i (beq) or ~zero_i (bne); next FETCH.
REQ-025 JUMP: PCSource_o=10, pc_write_o=1; next FETCH.
REQ-026 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready_i=0 there; when it reaches MEM_TIMEOUT with mem_ready_i still 0, next state TRAP and timeout_o set.
REQ-027 mem_ready_i SHALL be ignored outside FETCH/MEM_RD/MEM_WR; mem_ready_i=1 on the timeout cycle completes the access (ready wins).
REQ-028 TRAP: all strobes 0, held until rst_i; illegal_o/timeout_o remain set.
REQ-029 All unlisted outputs SHALL be 0 in each state.

Reset
REQ-030 With rst_i=1 at a clock edge: state FETCH, counter 0, opcode register 0, illegal_o=0, timeout_o=0, regardless of current state, including mid-access.
REQ-031 During reset cycle outputs SHALL reflect FETCH only after the edge; memory strobes asserted pre-reset are abandoned.

Configuration
REQ-032 Macro MULTICYCLE_CTRL_JAL_EN: defined -> JAL state: RegWrite_o=1, RegDst_o=10 ($31), MemtoReg_o=10 (PC), PCSource_o=10, pc_write_o=1, next FETCH; undefined -> jal is illegal (TRAP, illegal_o=1) and state 10 unreachable.

Verification
REQ-033 Reset, addi with mem_ready_i tied 1 -> states 0,1,6,7,0; RegWrite_o=1 only in ALU_WB; 4 cycles per instruction.
REQ-034 lw with mem_ready_i low 3 cycles in MEM_RD -> 0,1,2,3,3,3,3,4,0; mem_read_o high all four MEM_RD cycles.
REQ-035 beq zero_i=0 then bne zero_i=0 -> pc_write_o 0 then 1 in BRANCH; ALU_op 001 then 101.
REQ-036 opcode 111111 -> TRAP, illegal_o=1 held 20 cycles; rst_i -> FETCH, flags 0.
REQ-037 MEM_TIMEOUT=4, mem_ready_i=0 in FETCH -> TRAP after 4 wait cycles, timeout_o=1; ready on cycle 4 instead -> DECODE.
REQ-038 jal with and without MULTICYCLE_CTRL_JAL_EN -> state 10 with RegDst_o=10 / TRAP with illegal_o=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle controller.
// The master modport is the controller side, the slave modport the datapath side.
interface multicycle_ctrl_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          instr_op_i;
    logic                zero_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                ir_write_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                RegWrite_o;
    logic                ALUSrcA_o;
    logic [1:0]          RegDst_o;
    logic [1:0]          ALUSrcB_o;
    logic [1:0]          MemtoReg_o;
    logic [1:0]          PCSource_o;
    logic [ALU_OP_W-1:0] ALU_op_o;
    logic                illegal_o;
    logic                timeout_o;
    logic [3:0]          state_o;

    modport master (
        input  instr_op_i, zero_i, mem_ready_i,
        output pc_write_o, ir_write_o, mem_read_o, mem_write_o, RegWrite_o, ALUSrcA_o,
               RegDst_o, ALUSrcB_o, MemtoReg_o, PCSource_o, ALU_op_o,
               illegal_o, timeout_o, state_o
    );

    modport slave (
        output instr_op_i, zero_i, mem_ready_i,
        input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, RegWrite_o, ALUSrcA_o,
               RegDst_o, ALUSrcB_o, MemtoReg_o, PCSource_o, ALU_op_o,
               illegal_o, timeout_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory wait/timeout supervision.
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN (adds the JAL link state;
// without it jal decodes as an illegal opcode).
module multicycle_ctrl #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                clk_i,
    input logic                rst_i,
    multicycle_ctrl_if.master  bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_ORI   = 3'b011;
    localparam logic [2:0] ALU_FUNCT = 3'b100;
    localparam logic [2:0] ALU_BNE   = 3'b101;
    localparam logic [2:0] ALU_SLTI  = 3'b110;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       in_wait;
    logic       mem_expired;

    // EXEC-stage ALU code for the immediate / R-type arithmetic group
    function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
        case (op)
            OP_RTYPE: return ALU_FUNCT;
            OP_SLTI:  return ALU_SLTI;
            OP_ORI:   return ALU_ORI;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Memory-wait states count not-ready cycles; the last allowed one traps unless ready arrives
    always_comb begin
        in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        mem_expired = in_wait && !bus.mem_ready_i && (wait_cnt_q == WAIT_LAST);
    end

    // Next-state, opcode latch, wait counter and sticky error flags
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        wait_cnt_d = 8'd0;
        if (in_wait && !bus.mem_ready_i)
            wait_cnt_d = wait_cnt_q + 8'd1;
        case (state_q)
            S_FETCH:    if (bus.mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.instr_op_i;
                case (bus.instr_op_i)
                    OP_LW, OP_SW:                               state_d = S_MEM_ADDR;
                    OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_d = S_EXEC;
                    OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
                    OP_J:                                       state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:                                     state_d = S_JAL;
`else
                    OP_JAL: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
`endif
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready_i) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL:      state_d = S_FETCH;
`else
            S_JAL:      state_d = S_TRAP;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (mem_expired) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end
    end

    // State register with synchronous reset that abandons any access in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            op_q       <= 6'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Datapath controls decoded from the current state (Moore, plus ready/zero qualified writes)
    always_comb begin
        logic [2:0] alu_op;
        alu_op             = ALU_ADD;
        bus.pc_write_o     = 1'b0;
        bus.ir_write_o     = 1'b0;
        bus.mem_read_o     = 1'b0;
        bus.mem_write_o    = 1'b0;
        bus.RegWrite_o     = 1'b0;
        bus.ALUSrcA_o      = 1'b0;
        bus.RegDst_o       = 2'b00;
        bus.ALUSrcB_o      = 2'b00;
        bus.MemtoReg_o     = 2'b00;
        bus.PCSource_o     = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.mem_read_o = 1'b1;
                bus.ALUSrcB_o  = 2'b01;
                bus.ir_write_o = bus.mem_ready_i;
                bus.pc_write_o = bus.mem_ready_i;
            end
            S_DECODE:   bus.ALUSrcB_o = 2'b11;
            S_MEM_ADDR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = 2'b10;
            end
            S_MEM_RD:   bus.mem_read_o = 1'b1;
            S_MEM_WB: begin
                bus.RegWrite_o = 1'b1;
                bus.MemtoReg_o = 2'b01;
            end
            S_MEM_WR:   bus.mem_write_o = 1'b1;
            S_EXEC: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = (op_q == OP_RTYPE) ? 2'b00 : 2'b10;
                alu_op        = exec_alu_op(op_q);
            end
            S_ALU_WB: begin
                bus.RegWrite_o = 1'b1;
                bus.RegDst_o   = (op_q == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                bus.ALUSrcA_o  = 1'b1;
                bus.PCSource_o = 2'b01;
                if (op_q == OP_BNE) begin
                    alu_op         = ALU_BNE;
                    bus.pc_write_o = !bus.zero_i;
                end else begin
                    alu_op         = ALU_SUB;
                    bus.pc_write_o = bus.zero_i;
                end
            end
            S_JUMP: begin
                bus.PCSource_o = 2'b10;
                bus.pc_write_o = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL: begin
                bus.RegWrite_o = 1'b1;
                bus.RegDst_o   = 2'b10;
                bus.MemtoReg_o = 2'b10;
                bus.PCSource_o = 2'b10;
                bus.pc_write_o = 1'b1;
            end
`endif
            default: ;
        endcase
        bus.ALU_op_o = ALU_OP_W'(alu_op);
    end

    assign bus.illegal_o = illegal_q;
    assign bus.timeout_o = timeout_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver walks instructions through a
// per-instruction cycle model and queues the expected controls; a monitor on the
// falling edge pops and compares against the DUT.
module tb_multicycle_ctrl;
    localparam int TO  = 4;
    localparam int OPW = 4;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                           MEM_WB = 4'd4, MEM_WR = 4'd5, EXEC = 4'd6, ALU_WB = 4'd7,
                           BRANCH = 4'd8, JUMP = 4'd9, JAL = 4'd10, TRAP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;

    typedef struct packed {
        logic [3:0]     st;
        logic           pcw, irw, mrd, mwr, rw, asa;
        logic [1:0]     rd, asb, m2r, pcs;
        logic [OPW-1:0] aop;
        logic           ill, tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    multicycle_ctrl_if #(.ALU_OP_W(OPW)) bus();

    multicycle_ctrl #(.ALU_OP_W(OPW), .MEM_TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic m_ill, m_tmo;

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.ill = m_ill;
        e.tmo = m_tmo;
        return e;
    endfunction

    // Monitor: compare every cycle for which an expectation was queued
    always @(negedge clk) begin
        exp_t e, a;
        if (sb.size() > 0) begin
            e     = sb.pop_front();
            a.st  = bus.state_o;   a.pcw = bus.pc_write_o;  a.irw = bus.ir_write_o;
            a.mrd = bus.mem_read_o; a.mwr = bus.mem_write_o; a.rw = bus.RegWrite_o;
            a.asa = bus.ALUSrcA_o; a.rd = bus.RegDst_o;     a.asb = bus.ALUSrcB_o;
            a.m2r = bus.MemtoReg_o; a.pcs = bus.PCSource_o; a.aop = bus.ALU_op_o;
            a.ill = bus.illegal_o; a.tmo = bus.timeout_o;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL ctrl t=%0t got st=%0d pcw=%b irw=%b mrd=%b mwr=%b rw=%b asa=%b rd=%b asb=%b m2r=%b pcs=%b aop=%b ill=%b tmo=%b | want st=%0d pcw=%b irw=%b mrd=%b mwr=%b rw=%b asa=%b rd=%b asb=%b m2r=%b pcs=%b aop=%b ill=%b tmo=%b",
                         $time, a.st, a.pcw, a.irw, a.mrd, a.mwr, a.rw, a.asa, a.rd, a.asb, a.m2r, a.pcs, a.aop, a.ill, a.tmo,
                         e.st, e.pcw, e.irw, e.mrd, e.mwr, e.rw, e.asa, e.rd, e.asb, e.m2r, e.pcs, e.aop, e.ill, e.tmo);
            end
        end
    end

    // One clock cycle: apply inputs, queue the expected controls, advance past the edge
    task automatic cyc(input exp_t e, input logic rdy, input logic z, input logic [5:0] op, input logic r);
        bus.mem_ready_i = rdy;
        bus.zero_i      = z;
        bus.instr_op_i  = op;
        rst             = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (r) begin
            m_ill = 1'b0;
            m_tmo = 1'b0;
        end
    endtask

    // A memory access taking w not-ready cycles; w >= TO exhausts the budget
    task automatic mem_wait(input exp_t pend, input exp_t done, input int w, input logic [5:0] ir,
                            output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < w && i < TO; i++)
            cyc(pend, 1'b0, rbit(), ir, 1'b0);
        if (w >= TO) begin
            m_tmo   = 1'b1;
            trapped = 1'b1;
        end else begin
            cyc(done, 1'b1, rbit(), ir, 1'b0);
        end
    endtask

    // Sit in TRAP for n cycles, then reset out of it (TRAP still visible in the reset cycle)
    task automatic trap_then_reset(input int n);
        for (int i = 0; i < n; i++)
            cyc(blank(TRAP), rbit(), rbit(), rop(), 1'b0);
        cyc(blank(TRAP), rbit(), rbit(), rop(), 1'b1);
    endtask

    // Whole instruction: fetch (fw waits), decode, then the opcode's own sequence
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw, input int hold);
        exp_t e, done;
        bit   trapped;
        e = blank(FETCH); e.mrd = 1'b1; e.asb = 2'b01;
        done = e; done.irw = 1'b1; done.pcw = 1'b1;
        mem_wait(e, done, fw, op, trapped);
        if (trapped) begin
            trap_then_reset(hold);
            return;
        end
        e = blank(DECODE); e.asb = 2'b11;
        cyc(e, rbit(), rbit(), op, 1'b0);
        case (op)
            OP_LW, OP_SW: begin
                e = blank(MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10;
                cyc(e, rbit(), rbit(), rop(), 1'b0);
                e = blank(op == OP_LW ? MEM_RD : MEM_WR);
                if (op == OP_LW) e.mrd = 1'b1; else e.mwr = 1'b1;
                mem_wait(e, e, mw, rop(), trapped);
                if (trapped) begin
                    trap_then_reset(hold);
                    return;
                end
                if (op == OP_LW) begin
                    e = blank(MEM_WB); e.rw = 1'b1; e.m2r = 2'b01;
                    cyc(e, rbit(), rbit(), rop(), 1'b0);
                end
            end
            OP_R, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: begin
                e = blank(EXEC); e.asa = 1'b1;
                e.asb = (op == OP_R) ? 2'b00 : 2'b10;
                e.aop = (op == OP_R) ? 4'd4 : (op == OP_SLTI) ? 4'd6 : (op == OP_ORI) ? 4'd3 :
                        (op == OP_LUI) ? 4'd2 : 4'd0;
                cyc(e, rbit(), rbit(), rop(), 1'b0);
                e = blank(ALU_WB); e.rw = 1'b1; e.rd = (op == OP_R) ? 2'b01 : 2'b00;
                cyc(e, rbit(), rbit(), rop(), 1'b0);
            end
            OP_BEQ, OP_BNE: begin
                e = blank(BRANCH); e.asa = 1'b1; e.pcs = 2'b01;
                e.aop = (op == OP_BEQ) ? 4'd1 : 4'd5;
                e.pcw = (op == OP_BEQ) ? z : ~z;
                cyc(e, rbit(), z, rop(), 1'b0);
            end
            OP_J: begin
                e = blank(JUMP); e.pcs = 2'b10; e.pcw = 1'b1;
                cyc(e, rbit(), rbit(), rop(), 1'b0);
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL: begin
                e = blank(JAL); e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10; e.pcs = 2'b10; e.pcw = 1'b1;
                cyc(e, rbit(), rbit(), rop(), 1'b0);
            end
`endif
            default: begin
                m_ill = 1'b1;
                trap_then_reset(hold);
            end
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [11] = '{OP_R, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE,
                                 OP_LW, OP_SW, OP_J, OP_JAL};
        if ($urandom_range(0, 7) == 0) return rop();
        return tbl[$urandom_range(0, 10)];
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 11) == 0) return TO;
        return int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        exp_t e;
        bit   trapped;
        rst = 1'b1;
        bus.mem_ready_i = 1'b0;
        bus.zero_i      = 1'b0;
        bus.instr_op_i  = 6'd0;
        m_ill = 1'b0;
        m_tmo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(OP_ADDI, 1'b0, 0, 0, 1);
        run_instr(OP_ADDI, 1'b0, 0, 0, 1);
        run_instr(OP_LW, 1'b0, 0, 3, 1);
        run_instr(OP_SW, 1'b0, 2, 1, 1);
        run_instr(OP_BEQ, 1'b0, 0, 0, 1);
        run_instr(OP_BNE, 1'b0, 0, 0, 1);
        run_instr(OP_BEQ, 1'b1, 0, 0, 1);
        run_instr(OP_BNE, 1'b1, 0, 0, 1);
        run_instr(6'b111111, 1'b0, 0, 0, 20);
        run_instr(OP_R, 1'b0, TO, 0, 5);
        run_instr(OP_R, 1'b0, TO - 1, 0, 1);
        run_instr(OP_LW, 1'b0, 0, TO, 3);
        run_instr(OP_JAL, 1'b0, 0, 0, 3);
        run_instr(OP_J, 1'b0, 1, 0, 1);
        run_instr(OP_ORI, 1'b0, 0, 0, 1);
        run_instr(OP_LUI, 1'b0, 0, 0, 1);
        run_instr(OP_SLTI, 1'b0, 0, 0, 1);

        // Reset while a load is waiting on memory
        e = blank(FETCH); e.mrd = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(e, 1'b1, 1'b0, OP_LW, 1'b0);
        e = blank(DECODE); e.asb = 2'b11;
        cyc(e, 1'b0, 1'b0, OP_LW, 1'b0);
        e = blank(MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10;
        cyc(e, 1'b0, 1'b0, rop(), 1'b0);
        e = blank(MEM_RD); e.mrd = 1'b1;
        cyc(e, 1'b0, 1'b0, rop(), 1'b0);
        cyc(e, 1'b0, 1'b0, rop(), 1'b1);

        for (int n = 0; n < 250; n++)
            run_instr(pick_op(), rbit(), pick_wait(), pick_wait(), int'($urandom_range(0, 5)));

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
